// File: rtl/bus_router_pkg.sv
// ----------------------------------------------------------------------------
// bus_router_pkg
// Shared types and constants for the bus_router block.
//   state_t        : router FSM states (IDLE, POP, ROUTE, PUSH)
//   ID_W           : width of the destination ID field at the packet top
//   DEF_BROADCAST  : default destination ID meaning "every device but source"
//   id_of()        : extracts the destination ID from a packet of any width
// ----------------------------------------------------------------------------
package bus_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    ROUTE = 2'd2,
    PUSH  = 2'd3
  } state_t;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] DEF_BROADCAST = 8'hFF;

  // Widest packet id_of() can take; callers zero-extend into this width.
  localparam int MAX_PKT_W = 1024;
  localparam int PKT_IDX_W = $clog2(MAX_PKT_W) + 1;

  // The ID sits in the top byte of the packet, whatever its real width.
  function automatic logic [ID_W-1:0] id_of(input logic [MAX_PKT_W-1:0] pkt,
                                           input logic [PKT_IDX_W-1:0] pktW);
    return pkt[pktW - PKT_IDX_W'(1) -: ID_W];
  endfunction

endpackage

// File: rtl/bus_router_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The request vector is rotated so that
// position 0 corresponds to 'ptr', the first set bit is found, and the
// offset is mapped back to an absolute device index.
//   req     : request bits, one per device
//   ptr     : index with highest priority this cycle (must be < N)
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : binary index of the granted device
//   any     : at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  localparam logic [PW:0] N_EXT = (PW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic           w_found;
  logic [PW:0]    w_sum;

  // Doubling the vector lets a plain right shift act as a rotation.
  assign w_dbl = {req, req};
  assign w_rot = N'(w_dbl >> ptr);

  // Lowest set bit of the rotated vector is the winner's distance from ptr.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_off   = PW'(j);
      end
    end
  end

  // Map the offset back to an absolute index, wrapping modulo N.
  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= N_EXT) begin
      gnt_idx = PW'(w_sum - N_EXT);
    end else begin
      gnt_idx = PW'(w_sum);
    end
    any = w_found;
    gnt = w_found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/bus_router.sv
// ----------------------------------------------------------------------------
// bus_router
// N-port packet router. Arbitrates round-robin among pending device FIFOs,
// pops one packet, decodes its destination ID and delivers it to the
// addressed device, or to all other devices on broadcast.
//   clk       : system clock (rising edge)
//   reset     : synchronous active-high reset
//   pndng     : per-device "FIFO head valid"
//   D_pop     : per-device FIFO head data
//   pop       : one-cycle dequeue strobe, one-hot
//   push      : one-cycle delivery strobe, destination mask
//   D_push    : delivered packet, replicated on every lane, held after PUSH
//   busy      : FSM is not in IDLE
//   drop_cnt  : wrapping count of undeliverable packets
// ----------------------------------------------------------------------------
module bus_router
  import bus_router_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = DEF_BROADCAST
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic                            busy,
  output logic [15:0]                     drop_cnt
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [PW-1:0]      r_src;
  logic [drvrs-1:0]   r_srcOh;
  logic [PW-1:0]      r_rrPtr;
  logic [pckg_sz-1:0] r_hold;
  logic [drvrs-1:0]   r_push;
  logic [pckg_sz-1:0] r_dPush;
  logic [15:0]        r_dropCnt;

  logic [drvrs-1:0]   w_gnt;
  logic [PW-1:0]      w_gntIdx;
  logic               w_any;
  logic [ID_W-1:0]    w_id;
  logic [drvrs-1:0]   w_mask;

  rr_arbiter #(.N(drvrs), .PW(PW)) u_arb (
    .req     (pndng),
    .ptr     (r_rrPtr),
    .gnt     (w_gnt),
    .gnt_idx (w_gntIdx),
    .any     (w_any)
  );

  // Destination decode; broadcast wins over a numeric match, and a packet
  // addressed to its own source is treated as undeliverable.
  always_comb begin
    w_id   = id_of(MAX_PKT_W'(r_hold), PKT_IDX_W'(pckg_sz));
    w_mask = '0;
    if (w_id == broadcast) begin
      w_mask = ~r_srcOh;
    end else if ((w_id < ID_W'(drvrs)) && (w_id != ID_W'(r_src))) begin
      w_mask = drvrs'(1) << w_id;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a drop skips PUSH and returns straight to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_any) w_nextState = POP;
      POP:     w_nextState = ROUTE;
      ROUTE:   w_nextState = (w_mask != '0) ? PUSH : IDLE;
      PUSH:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers. push is loaded on the way into PUSH and cleared on
  // every other edge so it can never stay high for two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= '0;
      r_srcOh   <= '0;
      r_rrPtr   <= '0;
      r_hold    <= '0;
      r_push    <= '0;
      r_dPush   <= '0;
      r_dropCnt <= '0;
    end else begin
      r_push <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_src   <= w_gntIdx;
            r_srcOh <= w_gnt;
          end
        end
        POP: begin
          r_hold  <= D_pop[r_src];
          r_rrPtr <= (r_src == PW'(drvrs - 1)) ? '0 : r_src + 1'b1;
        end
        ROUTE: begin
          if (w_mask != '0) begin
            r_push  <= w_mask;
            r_dPush <= r_hold;
          end else begin
            r_dropCnt <= r_dropCnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    pop  = (r_state == POP) ? r_srcOh : '0;
    busy = (r_state != IDLE);
  end

  assign push     = r_push;
  assign D_push   = {drvrs{r_dPush}};
  assign drop_cnt = r_dropCnt;

endmodule
